// File: rtl/ysyx_23060337_keyed_lut_pkg.sv
// Shared constants and helpers for the keyed lookup table.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ysyx_23060337_keyed_lut_pkg;

  // Statistics counters width and their saturation ceiling.
  localparam int              CNT_LEN = 16;
  localparam logic [CNT_LEN-1:0] CNT_SAT = 16'hFFFF;

  // Increment that sticks at the ceiling instead of wrapping.
  function automatic logic [CNT_LEN-1:0] sat_inc(input logic [CNT_LEN-1:0] v);
    return (v == CNT_SAT) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ysyx_23060337_prio_match.sv
// Lowest-index priority pick over a match vector.
// Latency: combinational.
// Backpressure: none.
module ysyx_23060337_prio_match #(
  parameter int NR_KEY  = 4,
  parameter int IDX_LEN = 2
) (
  input  logic [NR_KEY-1:0]  match,
  output logic               hit,
  output logic [IDX_LEN-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last to write idx.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        idx = IDX_LEN'(i);
      end
    end
  end

endmodule

// File: rtl/ysyx_23060337_keyed_lut.sv
// Small flop-based key->data table with a one-deep registered lookup result.
// Latency: 1 cycle from lookup accept to res_valid.
// Backpressure: lk_ready drops while a result is held with res_ready low.
module ysyx_23060337_keyed_lut
  import ysyx_23060337_keyed_lut_pkg::*;
#(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 8,
  parameter int DATA_LEN    = 32,
  parameter bit HAS_DEFAULT = 1'b1,
  localparam int IDX_LEN    = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic                wr_clr,
  input  logic [IDX_LEN-1:0]  wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                lk_valid,
  output logic                lk_ready,
  input  logic [KEY_LEN-1:0]  lk_key,
  input  logic [DATA_LEN-1:0] default_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_LEN-1:0] res_data,
  output logic                res_hit,
  output logic [IDX_LEN-1:0]  res_idx,
  output logic [CNT_LEN-1:0]  hit_cnt,
  output logic [CNT_LEN-1:0]  miss_cnt
);

  logic [NR_KEY-1:0]   tbl_vld;
  logic [KEY_LEN-1:0]  tbl_key  [NR_KEY];
  logic [DATA_LEN-1:0] tbl_data [NR_KEY];

  logic [NR_KEY-1:0]   match;
  logic                m_hit;
  logic [IDX_LEN-1:0]  m_idx;
  logic [DATA_LEN-1:0] m_data;
  logic                accept;

  assign lk_ready = !res_valid || res_ready;
  assign accept   = lk_valid && lk_ready;

  // Valid bits: set on write, cleared on wr_clr. Out-of-range indices
  // never equal any loop index, so they leave the table untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_vld <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (wr_idx == IDX_LEN'(i)) tbl_vld[i] <= !wr_clr;
      end
    end
  end

  // Key/data storage carries no reset; a cleared entry's payload is ignored.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_clr) begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (wr_idx == IDX_LEN'(i)) begin
          tbl_key[i]  <= wr_key;
          tbl_data[i] <= wr_data;
        end
      end
    end
  end

  // Per-entry compare against the current (pre-write) table contents.
  always_comb begin
    match = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      match[i] = tbl_vld[i] && (tbl_key[i] == lk_key);
    end
  end

  ysyx_23060337_prio_match #(
    .NR_KEY  (NR_KEY),
    .IDX_LEN (IDX_LEN)
  ) u_prio (
    .match (match),
    .hit   (m_hit),
    .idx   (m_idx)
  );

  // Mux the winning entry's data; falls back to the miss value otherwise.
  always_comb begin
    m_data = HAS_DEFAULT ? default_out : '0;
    if (m_hit) begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (m_idx == IDX_LEN'(i)) m_data = tbl_data[i];
      end
    end
  end

  // Result register: loads on accept, otherwise holds until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_hit   <= 1'b0;
      res_idx   <= '0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_data  <= m_data;
      res_hit   <= m_hit;
      res_idx   <= m_hit ? m_idx : '0;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Saturating hit/miss statistics, one bump per accepted lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (m_hit) hit_cnt  <= sat_inc(hit_cnt);
      else       miss_cnt <= sat_inc(miss_cnt);
    end
  end

endmodule

// File: tb/tb_ysyx_23060337_keyed_lut.sv
module tb_ysyx_23060337_keyed_lut;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, wr_clr;
  logic [1:0]  wr_idx;
  logic [7:0]  wr_key, lk_key;
  logic [31:0] wr_data, default_out;
  logic        lk_valid, res_ready;

  logic        lk_ready, res_valid, res_hit;
  logic [31:0] res_data;
  logic [1:0]  res_idx;
  logic [15:0] hit_cnt, miss_cnt;

  // Second instance: 3 entries (idx 3 out of range), no default value.
  logic        lk_ready2, res_valid2, res_hit2;
  logic [31:0] res_data2;
  logic [1:0]  res_idx2;
  logic [15:0] hit_cnt2, miss_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060337_keyed_lut dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_clr(wr_clr), .wr_idx(wr_idx),
    .wr_key(wr_key), .wr_data(wr_data), .lk_valid(lk_valid), .lk_ready(lk_ready),
    .lk_key(lk_key), .default_out(default_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_hit(res_hit),
    .res_idx(res_idx), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  ysyx_23060337_keyed_lut #(.NR_KEY(3), .HAS_DEFAULT(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_clr(wr_clr), .wr_idx(wr_idx),
    .wr_key(wr_key), .wr_data(wr_data), .lk_valid(lk_valid), .lk_ready(lk_ready2),
    .lk_key(lk_key), .default_out(default_out), .res_valid(res_valid2),
    .res_ready(res_ready), .res_data(res_data2), .res_hit(res_hit2),
    .res_idx(res_idx2), .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [7:0] key, input logic [31:0] dat);
    wr_en = 1'b1; wr_clr = 1'b0; wr_idx = idx; wr_key = key; wr_data = dat;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_clr = 1'b0; wr_idx = '0; wr_key = '0;
    wr_data = '0; lk_valid = 1'b0; lk_key = '0; default_out = '0; res_ready = 1'b1;
    #3;
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_cnts", {hit_cnt, miss_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("lk_ready_after_rst", {31'd0, lk_ready}, 32'd1);

    // Two entries with the same key; lower index must win.
    wr(2'd0, 8'h11, 32'hAAAA0000);
    wr(2'd2, 8'h11, 32'hBBBB0000);

    lk_valid = 1'b1; lk_key = 8'h11;
    chk("no_result_before_edge", {31'd0, res_valid}, 32'd0);
    tick();
    lk_valid = 1'b0;
    chk("hit_valid", {31'd0, res_valid}, 32'd1);
    chk("hit_data", res_data, 32'hAAAA0000);
    chk("hit_flag_idx", {30'd0, res_hit, res_idx[0]}, 32'b10);
    chk("hit_cnt1", {16'd0, hit_cnt}, 32'd1);
    tick();
    chk("drop_valid", {31'd0, res_valid}, 32'd0);

    // Miss with default value, then back-to-back a hit on idx3
    // (out of range for the 3-entry instance).
    wr(2'd3, 8'h77, 32'h00007777);
    lk_valid = 1'b1; lk_key = 8'h55; default_out = 32'hDEADBEEF;
    tick();
    chk("miss_data", res_data, 32'hDEADBEEF);
    chk("miss_flag_idx", {29'd0, res_hit, res_idx}, 32'd0);
    chk("miss_cnt1", {16'd0, miss_cnt}, 32'd1);
    chk("nodef_miss_data", res_data2, 32'd0);
    lk_key = 8'h77;
    tick();
    lk_valid = 1'b0;
    chk("idx3_hit", {29'd0, res_hit, res_idx}, 32'b111);
    chk("idx3_data", res_data, 32'h00007777);
    chk("oor_write_ignored", {31'd0, res_hit2}, 32'd0);
    chk("oor_miss_data", res_data2, 32'd0);
    tick();

    // Backpressure: hold a hit for 3 cycles while rewriting its entry
    // and offering another lookup that must not be accepted.
    res_ready = 1'b0; lk_valid = 1'b1; lk_key = 8'h11;
    tick();
    lk_key = 8'h55;
    wr_en = 1'b1; wr_clr = 1'b0; wr_idx = 2'd0; wr_key = 8'h11; wr_data = 32'hCCCC0000;
    for (int c = 0; c < 3; c++) begin
      chk("hold_lk_ready", {31'd0, lk_ready}, 32'd0);
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_data", res_data, 32'hAAAA0000);
      chk("hold_hit_idx", {29'd0, res_hit, res_idx}, 32'b100);
      tick();
      wr_en = 1'b0;
    end
    lk_valid = 1'b0; res_ready = 1'b1;
    tick();
    chk("hold_release", {31'd0, res_valid}, 32'd0);
    chk("hold_cnts", {hit_cnt, miss_cnt}, {16'd3, 16'd1});

    // Same-cycle write and lookup sees the old table, next one sees the new.
    wr_en = 1'b1; wr_clr = 1'b0; wr_idx = 2'd1; wr_key = 8'h22; wr_data = 32'h1;
    lk_valid = 1'b1; lk_key = 8'h22; default_out = 32'h12345678;
    tick();
    wr_en = 1'b0;
    chk("wr_lk_same_miss", {31'd0, res_hit}, 32'd0);
    chk("wr_lk_same_data", res_data, 32'h12345678);
    tick();
    lk_valid = 1'b0;
    chk("b2b_valid", {31'd0, res_valid}, 32'd1);
    chk("b2b_hit_idx", {29'd0, res_hit, res_idx}, 32'b101);
    chk("b2b_data", res_data, 32'h1);

    // Invalidate idx0; the duplicate key at idx2 must now win.
    wr_en = 1'b1; wr_clr = 1'b1; wr_idx = 2'd0;
    tick();
    wr_en = 1'b0; wr_clr = 1'b0;
    lk_valid = 1'b1; lk_key = 8'h11;
    tick();
    lk_valid = 1'b0;
    chk("clr_hit_idx", {29'd0, res_hit, res_idx}, 32'b110);
    chk("clr_data", res_data, 32'hBBBB0000);
    chk("clr_cnts", {hit_cnt, miss_cnt}, {16'd5, 16'd2});

    // Asynchronous reset while a result is pending.
    res_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, res_valid}, 32'd0);
    chk("arst_data", res_data, 32'd0);
    chk("arst_cnts", {hit_cnt, miss_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; res_ready = 1'b1;
    lk_valid = 1'b1; lk_key = 8'h11; default_out = 32'h0;
    tick();
    lk_valid = 1'b0;
    chk("post_rst_miss", {29'd0, res_hit, res_idx}, 32'd0);
    chk("post_rst_cnts", {hit_cnt, miss_cnt}, {16'd0, 16'd1});
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
